radio_phy: RTL

- Radio-side responder for the controller's parallel radio interface (radio_enable / radio_send / radio_receive / radio_busy / radio_data).
- Serialises bytes from the controller onto tx_serial and deserialises bytes from rx_serial for the controller.
- Line format is UART-style: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), idle line high.
- Sits between the node controller and the RF modem's bit-level pins.

---
 rtl/radio_pkg.sv | 25 ++
 rtl/radio_baud_tick.sv | 34 +++
 rtl/radio_phy.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/radio_pkg.sv
// Shared definitions for the radio-side UART-style PHY: FSM encoding and line-format constants.
package radio_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        TX_START = 4'd1,
        TX_DATA  = 4'd2,
        TX_STOP  = 4'd3,
        RX_HUNT  = 4'd4,
        RX_START = 4'd5,
        RX_DATA  = 4'd6,
        RX_STOP  = 4'd7,
        RX_HOLD  = 4'd8
    } state_t;

    localparam int   FRAME_BITS = 10;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    // States in which the controller must treat the radio as occupied.
    function automatic logic state_is_busy(input state_t s);
        return (s != IDLE) && (s != RX_HOLD);
    endfunction

endpackage

// File: rtl/radio_baud_tick.sv
// Baud counter shared by TX and RX: wraps every CLKS_PER_BIT cycles, flags full-bit and half-bit points.
module radio_baud_tick #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic full_tick,
    output logic half_tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign full_tick = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign half_tick = (cnt_q == CNT_W'(CLKS_PER_BIT / 2 - 1));

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear || full_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/radio_phy.sv
// Half-duplex radio PHY: serialises controller bytes onto tx_serial and returns bytes received on rx_serial.
module radio_phy
    import radio_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       radio_enable,
    input  logic       radio_send,
    input  logic       radio_receive,
    inout  wire  [7:0] radio_data,
    output logic       radio_busy,
    output logic       tx_serial,
    input  logic       rx_serial,
    output logic       frame_err
);

    state_t     state_q, state_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_byte_q, rx_byte_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_err_q, frame_err_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;

    logic baud_clr;
    logic full_tick;
    logic half_tick;
    logic tx_req;
    logic rx_req;
    logic rx_keep;

    assign tx_req  = radio_enable & radio_send & ~radio_receive;
    assign rx_req  = radio_enable & radio_receive & ~radio_send;
    assign rx_keep = radio_enable & radio_receive;

    radio_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (baud_clr),
        .full_tick (full_tick),
        .half_tick (half_tick)
    );

    always_comb begin
        state_d     = state_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = rx_valid_q;
        frame_err_d = 1'b0;
        bit_cnt_d   = bit_cnt_q;
        baud_clr    = 1'b0;

        case (state_q)
            IDLE: begin
                baud_clr  = 1'b1;
                bit_cnt_d = '0;
                if (tx_req) begin
                    tx_shift_d = radio_data;
                    state_d    = TX_START;
                end else if (rx_req) begin
                    state_d = RX_HUNT;
                end
            end
            TX_START: begin
                if (full_tick) begin
                    state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (full_tick) begin
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (full_tick) begin
                    state_d = IDLE;
                end
            end
            RX_HUNT: begin
                baud_clr  = 1'b1;
                bit_cnt_d = '0;
                if (!rx_keep) begin
                    state_d = IDLE;
                end else if (rx_serial == START_BIT) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (!rx_keep) begin
                    state_d = IDLE;
                end else if (half_tick) begin
                    // Restart the counter here so later full ticks land mid-bit.
                    baud_clr = 1'b1;
                    state_d  = (rx_serial == START_BIT) ? RX_DATA : RX_HUNT;
                end
            end
            RX_DATA: begin
                if (!rx_keep) begin
                    state_d = IDLE;
                end else if (full_tick) begin
                    rx_shift_d = {rx_serial, rx_shift_q[7:1]};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (!rx_keep) begin
                    state_d = IDLE;
                end else if (full_tick) begin
                    if (rx_serial == STOP_BIT) begin
                        rx_byte_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = RX_HOLD;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RX_HUNT;
                    end
                end
            end
            RX_HOLD: begin
                baud_clr = 1'b1;
                if (!rx_keep) begin
                    rx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            bit_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    // Line level is decoded from registered state, so reset forces it high immediately.
    always_comb begin
        case (state_q)
            TX_START: tx_serial = START_BIT;
            TX_DATA:  tx_serial = tx_shift_q[0];
            default:  tx_serial = STOP_BIT;
        endcase
    end

    assign radio_busy = state_is_busy(state_q) || ((state_q == IDLE) && rx_req);
    assign frame_err  = frame_err_q;
    assign radio_data = (radio_receive && !radio_send && rx_valid_q) ? rx_byte_q : 8'hzz;

endmodule
